// File: rtl/candy_sram_arb.sv
// Two-port round-robin arbiter and command sequencer for the single-ported data SRAM.
// Port 0 is writeback, port 1 is the load/store unit; reads return on rvalid0/rvalid1.
module candy_sram_arb #(
  parameter int DW    = 32,
  parameter int AW    = 16,
  parameter int BURST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  logic          prio;
  logic [3:0]    cnt;
  logic          both;
  logic          grant;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          burst_more;
  logic          tag_v;
  logic          tag_p;

  // Winner selection and combinational accept; grants are suppressed during reset.
  always_comb begin
    both       = req0 & req1;
    grant      = (req0 | req1) & ~rst;
    sel        = 1'b0;
    burst_more = ({1'b0, cnt} + 5'd1) < 5'(BURST);
    if (both) begin
      sel = prio;
    end else if (req1) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    gnt0 = grant & ~sel;
    gnt1 = grant & sel;
    if (sel) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
  end

  // Priority pointer and burst counter; an idle cycle clears the burst but keeps prio.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
      cnt  <= 4'd0;
    end else if (!grant) begin
      cnt  <= 4'd0;
    end else if (both && burst_more) begin
      prio <= sel;
      cnt  <= cnt + 4'd1;
    end else begin
      prio <= ~sel;
      cnt  <= 4'd0;
    end
  end

  // SRAM command registers; address and write data hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_ce <= grant;
      sram_we <= grant & sel_we;
      if (grant) begin
        sram_addr  <= sel_addr;
        sram_wdata <= sel_wdata;
      end
    end
  end

  // Read tag pipe: the tag follows the command, then steers the captured data to its port.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v   <= 1'b0;
      tag_p   <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      tag_v   <= grant & ~sel_we;
      tag_p   <= sel;
      rvalid0 <= tag_v & ~tag_p;
      rvalid1 <= tag_v & tag_p;
      if (tag_v) begin
        rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_candy_sram_arb.sv
// Directed bench for candy_sram_arb: one BURST=1 instance with an SRAM model,
// one BURST=3 instance for the burst-allowance arbitration pattern.
module tb_candy_sram_arb;

  logic        clk = 1'b0;
  logic        rst;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  logic        a_req0, a_req1, a_we0, a_we1;
  logic [15:0] a_addr0, a_addr1;
  logic [31:0] a_wdata0, a_wdata1;
  logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1;
  logic [31:0] a_rdata;
  logic        a_sram_ce, a_sram_we;
  logic [15:0] a_sram_addr;
  logic [31:0] a_sram_wdata, a_sram_rdata;
  logic [31:0] mem [0:255];

  logic        b_req0, b_req1;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
  logic [31:0] b_rdata;
  logic        b_sram_ce, b_sram_we;
  logic [15:0] b_sram_addr;
  logic [31:0] b_sram_wdata;

  string bpat = "BBBBBBBBB-BBBB-BB-BBBB-00000";
  string bexp = "000111000n1110n00n0001n00000";

  always #5 clk = ~clk;

  candy_sram_arb #(.DW(32), .AW(16), .BURST(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata(a_rdata), .sram_ce(a_sram_ce), .sram_we(a_sram_we),
    .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata)
  );

  candy_sram_arb #(.DW(32), .AW(16), .BURST(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
    .addr0(16'h0001), .addr1(16'h0002), .wdata0(32'h0), .wdata1(32'h0),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata(b_rdata), .sram_ce(b_sram_ce), .sram_we(b_sram_we),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_rdata(32'h0)
  );

  // SRAM model: writes on the edge after the command is presented; reset fills A000_00xx.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (a_sram_ce && a_sram_we) begin
      mem[a_sram_addr[7:0]] <= a_sram_wdata;
    end
  end
  assign a_sram_rdata = mem[a_sram_addr[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte c;
    byte e;
    rst = 1'b1;
    a_req0 = 1'b1; a_req1 = 1'b1; a_we0 = 1'b0; a_we1 = 1'b0;
    a_addr0 = 16'h0; a_addr1 = 16'h0; a_wdata0 = 32'h0; a_wdata1 = 32'h0;
    b_req0 = 1'b0; b_req1 = 1'b0;
    #1;
    chk("rst_gnt0", a_gnt0, 1'b0);
    chk("rst_gnt1", a_gnt1, 1'b0);
    cyc();
    a_req0 = 1'b0; a_req1 = 1'b0;
    #1;
    chk("rst_ce", a_sram_ce, 1'b0);
    chk("rst_we", a_sram_we, 1'b0);
    chk("rst_addr", a_sram_addr, 16'h0);
    chk("rst_wdata", a_sram_wdata, 32'h0);
    chk("rst_rvalid0", a_rvalid0, 1'b0);
    chk("rst_rvalid1", a_rvalid1, 1'b0);
    chk("rst_rdata", a_rdata, 32'h0);
    cyc();
    rst = 1'b0;

    // Port-1 write then read back.
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 16'h0010; a_wdata1 = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt1", a_gnt1, 1'b1);
    chk("wr_gnt0", a_gnt0, 1'b0);
    cyc();
    a_we1 = 1'b0;
    #1;
    chk("wr_ce", a_sram_ce, 1'b1);
    chk("wr_we", a_sram_we, 1'b1);
    chk("wr_addr", a_sram_addr, 16'h0010);
    chk("wr_wdata", a_sram_wdata, 32'hDEAD_BEEF);
    chk("rd_gnt1", a_gnt1, 1'b1);
    cyc();
    a_req1 = 1'b0;
    #1;
    chk("rd_ce", a_sram_ce, 1'b1);
    chk("rd_we", a_sram_we, 1'b0);
    chk("rd_addr", a_sram_addr, 16'h0010);
    cyc();
    #1;
    chk("rd_rvalid1", a_rvalid1, 1'b1);
    chk("rd_rvalid0", a_rvalid0, 1'b0);
    chk("rd_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("idle_ce", a_sram_ce, 1'b0);
    chk("idle_we", a_sram_we, 1'b0);
    cyc();

    // Both ports read every cycle: strict alternation starting with port 0.
    for (int i = 0; i < 6; i++) begin
      a_req0 = (i < 4); a_we0 = 1'b0; a_addr0 = 16'h0040;
      a_req1 = (i < 4); a_we1 = 1'b0; a_addr1 = 16'h0050;
      #1;
      chk("alt_gnt0", a_gnt0, (i < 4) && (i % 2 == 0));
      chk("alt_gnt1", a_gnt1, (i < 4) && (i % 2 == 1));
      if (i >= 2) begin
        chk("alt_rvalid0", a_rvalid0, (i % 2 == 0));
        chk("alt_rvalid1", a_rvalid1, (i % 2 == 1));
        chk("alt_rdata", a_rdata, (i % 2 == 0) ? 32'hA000_0040 : 32'hA000_0050);
      end
      cyc();
    end

    // Same-cycle write (port 0) and read (port 1) of one address.
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 16'h0020; a_wdata0 = 32'h1111_1111;
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 16'h0020;
    #1;
    chk("raw_gnt0", a_gnt0, 1'b1);
    chk("raw_gnt1_wait", a_gnt1, 1'b0);
    cyc();
    a_req0 = 1'b0;
    #1;
    chk("raw_gnt1", a_gnt1, 1'b1);
    chk("raw_gnt0_off", a_gnt0, 1'b0);
    chk("raw_wr_we", a_sram_we, 1'b1);
    chk("raw_wr_addr", a_sram_addr, 16'h0020);
    chk("raw_wr_wdata", a_sram_wdata, 32'h1111_1111);
    cyc();
    a_req1 = 1'b0;
    #1;
    chk("raw_rd_ce", a_sram_ce, 1'b1);
    chk("raw_rd_we", a_sram_we, 1'b0);
    cyc();
    #1;
    chk("raw_rvalid1", a_rvalid1, 1'b1);
    chk("raw_rdata", a_rdata, 32'h1111_1111);
    cyc();

    // Reset while a port-1 read is in flight.
    a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 16'h0050;
    #1;
    chk("mr_gnt1", a_gnt1, 1'b1);
    cyc();
    rst = 1'b1; a_req0 = 1'b1; a_we0 = 1'b0;
    #1;
    chk("mr_gnt0_forced", a_gnt0, 1'b0);
    chk("mr_gnt1_forced", a_gnt1, 1'b0);
    chk("mr_cmd_ce", a_sram_ce, 1'b1);
    cyc();
    rst = 1'b0;
    #1;
    chk("mr_rvalid1", a_rvalid1, 1'b0);
    chk("mr_rvalid0", a_rvalid0, 1'b0);
    chk("mr_rdata", a_rdata, 32'h0);
    chk("mr_ce", a_sram_ce, 1'b0);
    chk("mr_we", a_sram_we, 1'b0);
    chk("mr_addr", a_sram_addr, 16'h0);
    chk("mr_wdata", a_sram_wdata, 32'h0);
    chk("mr_first_gnt0", a_gnt0, 1'b1);
    chk("mr_first_gnt1", a_gnt1, 1'b0);
    cyc();
    a_req0 = 1'b0; a_req1 = 1'b0;
    cyc();

    // BURST=3: B = both request, 0 = port 0 alone, - = idle; n = no grant.
    for (int i = 0; i < bpat.len(); i++) begin
      c = bpat[i];
      e = bexp[i];
      b_req0 = (c == "B") || (c == "0");
      b_req1 = (c == "B");
      #1;
      chk("burst_gnt0", b_gnt0, (e == "0"));
      chk("burst_gnt1", b_gnt1, (e == "1"));
      cyc();
    end
    b_req0 = 1'b0; b_req1 = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/candy_sram_arb.md
# candy_sram_arb

Two-port arbiter and sequencer for the single-ported data SRAM. Port 0 is the writeback stage, write-only in practice. Port 1 is the load/store unit, which reads and writes. The block accepts one request per cycle, chooses the winner by round-robin with a configurable burst allowance, drives the SRAM command registers, and routes synchronous read data back to the port that issued the read.

## Interface
Parameters:
- DW, 32: data width; matches `SRAMDataWidth.
- AW, 16: address width; matches `SRAMAddrWidth.
- BURST, 1: maximum consecutive grants to one port while the other port is requesting. Legal range is 1..15.

Ports:
- clk  in  1: clock. All logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- req0, req1  in  1: port request. Must be held, with we/addr/wdata stable, until the matching gnt is high.
- we0, we1  in  1: 1 = write, 0 = read.
- addr0, addr1  in  AW: request address.
- wdata0, wdata1  in  DW: write data. Ignored for reads.
- gnt0, gnt1  out  1: combinational accept, valid in the cycle the request is taken. At most one is high per cycle.
- rvalid0, rvalid1  out  1: registered one-cycle pulse marking read data for that port.
- rdata  out  DW: registered read data, shared by both ports. Qualify it with rvalid0/rvalid1.
- sram_ce  out  1: registered SRAM chip enable.
- sram_we  out  1: registered SRAM write enable.
- sram_addr  out  AW: registered SRAM address.
- sram_wdata  out  DW: registered SRAM write data.
- sram_rdata  in  DW: SRAM read data, valid one cycle after a read command (sram_ce=1, sram_we=0).

## Operation
State: priority pointer prio (1 bit) and burst counter cnt (4 bits).

Arbitration, evaluated each cycle:
- Neither port requests: no grant. prio is held and cnt is cleared.
- Only port p requests: grant p.
- Both ports request: grant prio.

Update after a grant to port p:
- If the other port also requested and cnt+1 < BURST: prio ← p and cnt ← cnt+1.
- Otherwise: prio ← other port and cnt ← 0.
- With BURST=1, simultaneous requests alternate strictly between the ports.

Command register, updated on every edge:
- sram_ce ← grant.
- When a grant occurs, sram_we/sram_addr/sram_wdata load from the granted port.
- When no grant occurs, sram_we ← 0 and sram_addr/sram_wdata hold their values.

Read return:
- A 2-stage tag pipe tracks issued reads: stage 1 = {read issued, port}, stage 2 = the same one cycle later.
- When stage 2 is valid, rdata ← sram_rdata and rvalid[port] ← 1.

Writes produce no response beyond gnt.

Ordering:
- Commands reach the SRAM in grant order.
- A read that follows a write to the same address returns the new data, because the SRAM is sequential. No forwarding logic is needed.

## Timing
- Grant: cycle t. The combinational path runs from req*/prio to gnt*.
- SRAM command: visible t+1.
- Read data: rvalid and rdata visible t+2, i.e. read latency 2 cycles from grant.
- Throughput: one command per cycle with back-to-back grants and no bubbles. Reads to either port may be issued every cycle.

Reset values: gnt0=gnt1=0 while rst is high (forced low); rvalid0=rvalid1=0; rdata=0; sram_ce=0; sram_we=0; sram_addr=0; sram_wdata=0; prio=0; cnt=0; tag pipe empty.

Reset mid-operation:
- In-flight reads are dropped and no rvalid occurs after the reset edge.
- The first grant after rst falls follows prio=0.

Boundary conditions:
- A port that drops req without receiving gnt is legal. Nothing is issued for that request.
- A port whose req stays high after gnt is treated as a new request in the next cycle.
- cnt saturation cannot occur because cnt < BURST ≤ 15.

## Test plan
- Write, then read back: reset, then a single port-1 write (addr 0x0010, data 0xDEADBEEF) → gnt1 at t; sram_ce=1, we=1, addr=0x0010 at t+1. A following port-1 read of 0x0010 → rvalid1=1 and rdata=0xDEADBEEF two cycles after its gnt.
- Both ports request reads every cycle with BURST=1 → grants alternate gnt0, gnt1, gnt0, …, starting with port 0. rvalid0/rvalid1 alternate with 2-cycle latency and each returns its own address's data.
- BURST=3, both requesting continuously → pattern 0,0,0,1,1,1,0,0,0. Port 0 requests alone for 5 cycles → 5 consecutive gnt0 with no forced handover.
- Port 0 write (0x0020, 0x11111111) and port 1 read of 0x0020 raised in the same cycle, prio=0 → write granted first, read granted next cycle. The read returns 0x11111111.
- Port 1 read granted, then rst asserted at t+1 for one cycle → no rvalid1 at t+2. All outputs are at reset values, and the next grant after reset goes to port 0 under contention.
- Idle cycles between requests → sram_ce=0 and sram_we=0 during the idle cycles, cnt clears, and prio is unchanged.
